// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encodings and the
// default operand width used by the controller, operand registers and bench.
package serial_adder_pkg;

  localparam int unsigned SIZE_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    FIN  = 2'd3
  } state_e;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder used as the arithmetic core of the serial adder.
module full_adder_bit
  import serial_adder_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = majority(i_a, i_b, i_cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer and bit-serial arithmetic for the serial adder: loads the operand
// shift registers, adds/subtracts one bit per cycle and reports carry/overflow.
//
// Handshake: START is a request sampled only in IDLE (no ready signal; requests
// in other states are dropped). DONE is a one-cycle completion pulse carrying
// valid COUT/OVF, which then hold until the next operation's LOAD cycle.
module serial_add_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   START,
  input  logic   SUB,
  input  logic   A_LSB,
  input  logic   B_LSB,
  output logic   SR_EN,
  output logic   SR_LOAD,
  output logic   SUM_BIT,
  output logic   BUSY,
  output logic   DONE,
  output logic   COUT,
  output logic   OVF,
  output state_e o_dbg_state
);

  localparam int unsigned CNT_W = $clog2(SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;
  logic             r_sub;
  logic             r_cout;
  logic             r_ovf;

  logic w_b;
  logic w_sum;
  logic w_carry_next;

  // Subtraction is A + ~B + 1: invert B here, the +1 comes from the carry preset in LOAD.
  assign w_b = B_LSB ^ r_sub;

  full_adder_bit u_fa (
    .i_a    (A_LSB),
    .i_b    (w_b),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_carry_next)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_count <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            r_sub   <= SUB;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_carry <= r_sub;
          r_count <= '0;
          r_cout  <= 1'b0;
          r_ovf   <= 1'b0;
          r_state <= ADD;
        end
        ADD: begin
          r_carry <= w_carry_next;
          r_count <= r_count + CNT_W'(1);
          // MSB cycle: overflow is carry into the sign bit differing from carry out of it.
          if (r_count == CNT_LAST) begin
            r_cout  <= w_carry_next;
            r_ovf   <= r_carry ^ w_carry_next;
            r_state <= FIN;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign SR_EN       = (r_state == LOAD) || (r_state == ADD);
  assign SR_LOAD     = (r_state == LOAD);
  assign BUSY        = (r_state == LOAD) || (r_state == ADD);
  assign DONE        = (r_state == FIN);
  assign SUM_BIT     = (r_state == ADD) && w_sum;
  assign COUT        = r_cout;
  assign OVF         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Control and arithmetic stage of the serial adder: owns the bit-serial full adder, the carry flip-flop and the sequencing FSM. It drives the enable/load of the operand shift registers, consumes their LSBs each cycle and returns the sum bit as the serial input of the A/result register. A START pulse runs one SIZE-bit add or subtract, then DONE reports completion with carry-out and signed overflow flags.

## Interface
- SIZE, 8: operand width in bits; legal range ≥ 2.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset. Single clock domain.
- START  in  1  request an operation; sampled only in IDLE.
- SUB  in  1  0 = A+B, 1 = A−B; captured with START.
- A_LSB  in  1  bit 0 of operand A/result shift register.
- B_LSB  in  1  bit 0 of operand B shift register.
- SR_EN  out  1  enable to both shift registers.
- SR_LOAD  out  1  parallel-load select to both shift registers.
- SUM_BIT  out  1  serial sum bit, to BIT_IN of the A/result register.
- BUSY  out  1  high in LOAD and ADD.
- DONE  out  1  one-cycle completion pulse.
- COUT  out  1  final carry-out. For SUB this is the no-borrow flag.
- OVF  out  1  two's-complement overflow.

## Operation
- States: IDLE, LOAD, ADD, FIN.
- IDLE: SR_EN=0, SR_LOAD=0. When START=1: latch SUB into sub_r and go to LOAD.
- LOAD (1 cycle): SR_EN=1, SR_LOAD=1. Set carry to sub_r, count to 0, and clear COUT and OVF. Go to ADD.
- ADD (SIZE cycles): SR_EN=1, SR_LOAD=0.
  - b' = B_LSB ^ sub_r.
  - SUM_BIT = A_LSB ^ b' ^ carry (combinational).
  - carry updates to majority(A_LSB, b', carry).
  - count increments each cycle.
  - When count == SIZE−1: COUT takes the new carry, OVF takes carry_in ^ carry_out of this MSB bit, and the FSM goes to FIN.
- FIN (1 cycle): DONE=1, SR_EN=0. Go to IDLE.
- Counter width is $clog2(SIZE). All arithmetic is modulo 2^SIZE. The result is left in the A register after SIZE shifts.
- SUM_BIT is don't-care outside ADD and is driven 0 there.
- START in LOAD, ADD or FIN is ignored, not queued. START held high through FIN starts a new operation on the first IDLE cycle.
- SUB changes after the START cycle have no effect on the current operation.
- COUT and OVF hold their value from FIN until the next LOAD.
- Reset (any state, including mid-ADD): state=IDLE, count=0, carry=0, sub_r=0. Outputs BUSY, DONE, SR_EN, SR_LOAD, SUM_BIT, COUT and OVF are all 0. The partial result is discarded; the shift registers share RST.

## Timing
- START is sampled at edge 0. LOAD is active in cycle 1, and the registers load at edge 1.
- ADD covers cycles 2..SIZE+1; shift k happens at edge k+1.
- DONE is high in cycle SIZE+2. Latency from START to DONE is SIZE+2 cycles.
- Minimum START-to-START spacing is SIZE+3 cycles.
- SR_EN, SR_LOAD, BUSY and DONE are Moore decodes of the registered state (glitch-free, no input paths).
- SUM_BIT is combinational from A_LSB, B_LSB and registered carry/sub_r. The path is one full-adder delay.

## Structure
- Shared package serial_adder_pkg holds:
  - state encodings IDLE=2'd0, LOAD=2'd1, ADD=2'd2, FIN=2'd3;
  - the default SIZE constant used by controller, registers and bench.
- Sub-module full_adder_bit: combinational 1-bit full adder (a, b, cin → s, cout), instantiated once. The controller instantiates no shift registers.

## Test plan
Bench wraps the block with two SIZE=8 operand shift registers (A fed by SUM_BIT, B fed by 0).
- 0x35 + 0x4A, SUB=0 → A=0x7F, COUT=0, OVF=0; DONE exactly at cycle 10 after START.
- 0xFF + 0x01 → A=0x00, COUT=1, OVF=0. 0x7F + 0x01 → A=0x80, COUT=0, OVF=1.
- SUB=1: 0x10 − 0x20 → A=0xF0, COUT=0, OVF=0. 0x80 − 0x01 → A=0x7F, COUT=1, OVF=1.
- START pulsed in cycles 3 and 9 of a running op → ignored. A single DONE, correct result, BUSY continuous cycles 1..9.
- RST low in cycle 5 of ADD → all outputs 0 immediately (async). A new START after release gives a correct 0x35+0x4A result.
- Back-to-back: START held high → consecutive ops separated by 11 cycles. COUT/OVF stable from each FIN until the following LOAD.
